// File: rtl/gon_tag_gen_if.sv
// FIFO-side tag bus between the tag sequencer and the GON tags FIFO.
// The sequencer drives tag pairs and the write strobe; the FIFO returns full.
interface gon_tag_gen_if #(
    parameter int ROW_TAG_WIDTH = 4,
    parameter int COL_TAG_WIDTH = 4
);
    logic [ROW_TAG_WIDTH-1:0] row_tag;
    logic [COL_TAG_WIDTH-1:0] col_tag;
    logic                     tags_wr_en;
    logic                     tags_full;

    modport master (
        output row_tag,
        output col_tag,
        output tags_wr_en,
        input  tags_full
    );

    modport slave (
        input  row_tag,
        input  col_tag,
        input  tags_wr_en,
        output tags_full
    );
endinterface

// File: rtl/gon_tag_gen.sv
// Tag sequencer: walks a programmed (row, col) rectangle for N passes
// and pushes one tag pair per cycle into the GON tags FIFO.
module gon_tag_gen #(
    parameter int ROW_TAG_WIDTH = 4,
    parameter int COL_TAG_WIDTH = 4,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     clear,
    input  logic [ROW_TAG_WIDTH-1:0] cfg_row_first,
    input  logic [ROW_TAG_WIDTH-1:0] cfg_row_last,
    input  logic [COL_TAG_WIDTH-1:0] cfg_col_first,
    input  logic [COL_TAG_WIDTH-1:0] cfg_col_last,
    input  logic [CNT_WIDTH-1:0]     cfg_passes,
    gon_tag_gen_if.master            tags,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_WIDTH-1:0]     tag_count
);

    localparam logic [ROW_TAG_WIDTH-1:0] ROW_ONE = 1;
    localparam logic [COL_TAG_WIDTH-1:0] COL_ONE = 1;
    localparam logic [CNT_WIDTH-1:0]     CNT_ONE = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [ROW_TAG_WIDTH-1:0] row_first_q, row_first_d;
    logic [ROW_TAG_WIDTH-1:0] row_last_q, row_last_d;
    logic [COL_TAG_WIDTH-1:0] col_first_q, col_first_d;
    logic [COL_TAG_WIDTH-1:0] col_last_q, col_last_d;
    logic [CNT_WIDTH-1:0]     passes_q, passes_d;
    logic [CNT_WIDTH-1:0]     pass_q, pass_d;
    logic [ROW_TAG_WIDTH-1:0] row_q, row_d;
    logic [COL_TAG_WIDTH-1:0] col_q, col_d;
    logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;

    logic accept;
    logic empty_job;
    logic wr;
    logic last_col;
    logic last_row;
    logic last_pass;
    logic final_wr;

    // Wraps are driven by equality with the latched last values, so a
    // rectangle ending at the all-ones tag never relies on overflow.
    always_comb begin
        accept    = (state_q == ST_IDLE) && start && !clear;
        empty_job = (cfg_row_first > cfg_row_last)
                 || (cfg_col_first > cfg_col_last)
                 || (cfg_passes == '0);
        wr        = (state_q == ST_RUN) && !tags.tags_full && !clear;
        last_col  = (col_q == col_last_q);
        last_row  = (row_q == row_last_q);
        last_pass = (pass_q == (passes_q - CNT_ONE));
        final_wr  = wr && last_row && last_col && last_pass;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = empty_job ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (final_wr) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy            = (state_q == ST_RUN) || (state_q == ST_DONE);
        done            = (state_q == ST_DONE);
        tags.tags_wr_en = wr;
        tags.row_tag    = row_q;
        tags.col_tag    = col_q;
        tag_count       = cnt_q;
    end

    always_comb begin
        row_first_d = row_first_q;
        row_last_d  = row_last_q;
        col_first_d = col_first_q;
        col_last_d  = col_last_q;
        passes_d    = passes_q;
        pass_d      = pass_q;
        row_d       = row_q;
        col_d       = col_q;
        cnt_d       = cnt_q;
        unique case (1'b1)
            accept: begin
                row_first_d = cfg_row_first;
                row_last_d  = cfg_row_last;
                col_first_d = cfg_col_first;
                col_last_d  = cfg_col_last;
                passes_d    = cfg_passes;
                pass_d      = '0;
                row_d       = cfg_row_first;
                col_d       = cfg_col_first;
                cnt_d       = '0;
            end
            wr: begin
                cnt_d = cnt_q + CNT_ONE;
                if (last_col) begin
                    col_d = col_first_q;
                    if (last_row) begin
                        row_d  = row_first_q;
                        pass_d = pass_q + CNT_ONE;
                    end else begin
                        row_d = row_q + ROW_ONE;
                    end
                end else begin
                    col_d = col_q + COL_ONE;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_first_q <= '0;
            row_last_q  <= '0;
            col_first_q <= '0;
            col_last_q  <= '0;
            passes_q    <= '0;
            pass_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            cnt_q       <= '0;
        end else begin
            row_first_q <= row_first_d;
            row_last_q  <= row_last_d;
            col_first_q <= col_first_d;
            col_last_q  <= col_last_d;
            passes_q    <= passes_d;
            pass_q      <= pass_d;
            row_q       <= row_d;
            col_q       <= col_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_gon_tag_gen.sv
// Directed bench for gon_tag_gen: tag order, stalls, empty jobs,
// ignored restarts, clear, async reset and a full-range row sweep.
module tb_gon_tag_gen;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        clear;
    logic [3:0]  cfg_row_first;
    logic [3:0]  cfg_row_last;
    logic [3:0]  cfg_col_first;
    logic [3:0]  cfg_col_last;
    logic [15:0] cfg_passes;
    logic        busy;
    logic        done;
    logic [15:0] tag_count;

    gon_tag_gen_if #(.ROW_TAG_WIDTH(4), .COL_TAG_WIDTH(4)) tif ();

    gon_tag_gen #(
        .ROW_TAG_WIDTH(4),
        .COL_TAG_WIDTH(4),
        .CNT_WIDTH(16)
    ) dut (
        .clk          (clk),
        .reset        (rst_n),
        .start        (start),
        .clear        (clear),
        .cfg_row_first(cfg_row_first),
        .cfg_row_last (cfg_row_last),
        .cfg_col_first(cfg_col_first),
        .cfg_col_last (cfg_col_last),
        .cfg_passes   (cfg_passes),
        .tags         (tif),
        .busy         (busy),
        .done         (done),
        .tag_count    (tag_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    logic [7:0]  tq[$];
    logic [7:0]  exp_q[$];
    logic [31:0] wr_mask;
    logic [31:0] busy_mask;
    int          done_cyc;
    int          done_cnt;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_tags(input string nm);
        check({nm, "_ntags"}, tq.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < tq.size(); i++) begin
            check({nm, "_tag"}, 32'(tq[i]), 32'(exp_q[i]));
        end
    endtask

    // Entered and left at 1ns after a rising edge. Cycle c is the
    // interval after the c-th edge following the start edge.
    task automatic run_job(input logic [3:0] rf, input logic [3:0] rl,
                           input logic [3:0] cf, input logic [3:0] cl,
                           input logic [15:0] np,
                           input logic [31:0] full_mask,
                           input int poke_c, input int clr_c,
                           input int max_c);
        tq.delete();
        wr_mask   = '0;
        busy_mask = '0;
        done_cyc  = 0;
        done_cnt  = 0;
        cfg_row_first = rf;
        cfg_row_last  = rl;
        cfg_col_first = cf;
        cfg_col_last  = cl;
        cfg_passes    = np;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= max_c; c++) begin
            tif.tags_full = full_mask[c];
            clear = (c == clr_c);
            if (c == poke_c) begin
                start         = 1'b1;
                cfg_row_first = 4'd2;
                cfg_row_last  = 4'd3;
                cfg_col_first = 4'd5;
                cfg_col_last  = 4'd6;
                cfg_passes    = 16'd2;
            end
            @(negedge clk);
            if (tif.tags_wr_en) begin
                tq.push_back({tif.row_tag, tif.col_tag});
                wr_mask[c] = 1'b1;
            end
            if (busy) busy_mask[c] = 1'b1;
            if (done) begin
                done_cnt++;
                done_cyc = c;
            end
            @(posedge clk);
            #1;
            start         = 1'b0;
            clear         = 1'b0;
            tif.tags_full = 1'b0;
            if (done_cyc != 0 && c > done_cyc) break;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        start = 1'b0;
        clear = 1'b0;
        cfg_row_first = '0;
        cfg_row_last  = '0;
        cfg_col_first = '0;
        cfg_col_last  = '0;
        cfg_passes    = '0;
        tif.tags_full = 1'b0;
        #12;
        check("rst_wr", 32'(tif.tags_wr_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_row", 32'(tif.row_tag), 32'd0);
        check("rst_col", 32'(tif.col_tag), 32'd0);
        check("rst_cnt", 32'(tag_count), 32'd0);
        #5;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 2x3 rectangle, no back-pressure
        run_job(4'd0, 4'd1, 4'd0, 4'd2, 16'd1, 32'h0, 0, 0, 30);
        exp_q = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12};
        check_tags("t1");
        check("t1_wrmask", wr_mask, 32'h7E);
        check("t1_done", done_cyc, 7);
        check("t1_busy", busy_mask, 32'hFE);
        check("t1_cnt", 32'(tag_count), 32'd6);

        // full in cycles 2..4
        run_job(4'd0, 4'd1, 4'd0, 4'd2, 16'd1, 32'h1C, 0, 0, 30);
        check_tags("t2");
        check("t2_wrmask", wr_mask, 32'h3E2);
        check("t2_done", done_cyc, 10);
        check("t2_cnt", 32'(tag_count), 32'd6);

        // single tag, three passes
        run_job(4'd3, 4'd3, 4'd13, 4'd13, 16'd3, 32'h0, 0, 0, 30);
        exp_q = '{8'h3D, 8'h3D, 8'h3D};
        check_tags("t3");
        check("t3_wrmask", wr_mask, 32'hE);
        check("t3_done", done_cyc, 4);
        check("t3_cnt", 32'(tag_count), 32'd3);
        check("t3_row", 32'(tif.row_tag), 32'd3);
        check("t3_col", 32'(tif.col_tag), 32'd13);

        // empty: row_first > row_last
        run_job(4'd5, 4'd4, 4'd0, 4'd2, 16'd1, 32'h0, 0, 0, 30);
        check("e1_wrmask", wr_mask, 32'h0);
        check("e1_done", done_cyc, 1);
        check("e1_busy", busy_mask, 32'h2);
        check("e1_cnt", 32'(tag_count), 32'd0);

        // empty: zero passes
        run_job(4'd0, 4'd1, 4'd0, 4'd2, 16'd0, 32'h0, 0, 0, 30);
        check("e2_wrmask", wr_mask, 32'h0);
        check("e2_done", done_cyc, 1);
        check("e2_busy", busy_mask, 32'h2);

        // restart and cfg change at cycle 3 are ignored
        run_job(4'd0, 4'd1, 4'd0, 4'd2, 16'd1, 32'h0, 3, 0, 30);
        exp_q = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12};
        check_tags("t5");
        check("t5_done", done_cyc, 7);
        check("t5_cnt", 32'(tag_count), 32'd6);

        // clear at cycle 4
        run_job(4'd0, 4'd1, 4'd0, 4'd2, 16'd1, 32'h0, 0, 4, 6);
        exp_q = '{8'h00, 8'h01, 8'h02};
        check_tags("c1");
        check("c1_wrmask", wr_mask, 32'hE);
        check("c1_busy", busy_mask, 32'h1E);
        check("c1_ndone", done_cnt, 0);
        check("c1_cnt", 32'(tag_count), 32'd3);

        // async reset in cycle 3 of a run
        run_job(4'd0, 4'd1, 4'd0, 4'd2, 16'd1, 32'h0, 0, 0, 2);
        check("r_pre_wr", 32'(tif.tags_wr_en), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("r_wr", 32'(tif.tags_wr_en), 32'd0);
        check("r_busy", 32'(busy), 32'd0);
        check("r_done", 32'(done), 32'd0);
        check("r_row", 32'(tif.row_tag), 32'd0);
        check("r_col", 32'(tif.col_tag), 32'd0);
        check("r_cnt", 32'(tag_count), 32'd0);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_job(4'd1, 4'd2, 4'd4, 4'd5, 16'd1, 32'h0, 0, 0, 30);
        exp_q = '{8'h14, 8'h15, 8'h24, 8'h25};
        check_tags("r2");
        check("r2_done", done_cyc, 5);
        check("r2_cnt", 32'(tag_count), 32'd4);

        // all 16 rows, single column
        run_job(4'd0, 4'd15, 4'd0, 4'd0, 16'd1, 32'h0, 0, 0, 30);
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(8'(i << 4));
        check_tags("fr");
        check("fr_wrmask", wr_mask, 32'h1FFFE);
        check("fr_done", done_cyc, 17);
        check("fr_cnt", 32'(tag_count), 32'd16);
        check("fr_row", 32'(tif.row_tag), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
